// File: rtl/regfile_bypass_dump_pkg.sv
// Shared rv32i register-file definitions: default sizes, well-known indices
// and the dump engine state encoding.
package regfile_bypass_dump_pkg;

   localparam int unsigned XLEN_DEF     = 32;
   localparam int unsigned NREGS_DEF    = 32;
   localparam int unsigned X0           = 0;
   localparam int unsigned DISP_IDX_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } dump_state_e;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks the register index 0..NREGS-1 over a valid/ready
// handshake and pulses done once after the final word is accepted.
module regfile_dump_ctrl
   import regfile_bypass_dump_pkg::*;
#(
   parameter int unsigned AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          ready,
   input  logic          last,
   output logic          busy,
   output logic          valid,
   output logic          done,
   output logic [AW-1:0] idx
);

   dump_state_e   state, state_nxt;
   logic [AW-1:0] idx_nxt;
   logic          busy_nxt, valid_nxt, done_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         busy  <= 1'b0;
         valid <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         busy  <= busy_nxt;
         valid <= valid_nxt;
         done  <= done_nxt;
      end
   end

   // Outputs are decoded from the next state so they leave the flops aligned with it.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               idx_nxt   = '0;
            end
         end
         RUN: begin
            if (ready) begin
               if (last) state_nxt = DONE;
               else      idx_nxt   = idx + AW'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      busy_nxt  = (state_nxt != IDLE);
      valid_nxt = (state_nxt == RUN);
      done_nxt  = (state_nxt == DONE);
   end

endmodule

// File: rtl/regfile_bypass_dump.sv
// Parametrised integer register file: two write ports (port 1 wins), NRD
// bypassed read ports, hardwired x0, fixed display tap and a dump engine.
module regfile_bypass_dump
   import regfile_bypass_dump_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEF,
   parameter int unsigned NREGS    = NREGS_DEF,
   parameter int unsigned AW       = $clog2(NREGS),
   parameter int unsigned NRD      = 2,
   parameter int unsigned DISP_IDX = DISP_IDX_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   ra,
   output logic [NRD*XLEN-1:0] rd,
   input  logic                we0,
   input  logic [AW-1:0]       wa0,
   input  logic [XLEN-1:0]     wd0,
   input  logic                we1,
   input  logic [AW-1:0]       wa1,
   input  logic [XLEN-1:0]     wd1,
   output logic [XLEN-1:0]     display_data,
   input  logic                dump_start,
   output logic                dump_busy,
   output logic                dump_valid,
   input  logic                dump_ready,
   output logic [AW-1:0]       dump_idx,
   output logic [XLEN-1:0]     dump_data,
   output logic                dump_done
);

   logic [XLEN-1:0] regs [NREGS];
   logic            dump_last;

   // Port 1 is written second so it overrides port 0 on an address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
      end else begin
         if (we0 && (wa0 != AW'(X0))) regs[wa0] <= wd0;
         if (we1 && (wa1 != AW'(X0))) regs[wa1] <= wd1;
      end
   end

   for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;

      assign addr = ra[k*AW +: AW];

      always_comb begin
         data = regs[addr];
         if (addr == AW'(X0))                 data = '0;
         else if (we1 && (wa1 == addr))       data = wd1;
         else if (we0 && (wa0 == addr))       data = wd0;
      end

      assign rd[k*XLEN +: XLEN] = data;
   end

   // Display and dump taps see stored contents only, never in-flight writes.
   assign display_data = regs[AW'(DISP_IDX)];
   assign dump_data    = regs[dump_idx];
   assign dump_last    = (dump_idx == AW'(NREGS - 1));

   regfile_dump_ctrl #(
      .AW (AW)
   ) u_dump_ctrl (
      .clk   (clk),
      .rst   (rst),
      .start (dump_start),
      .ready (dump_ready),
      .last  (dump_last),
      .busy  (dump_busy),
      .valid (dump_valid),
      .done  (dump_done),
      .idx   (dump_idx)
   );

endmodule

// File: tb/tb_regfile_bypass_dump.sv
// Self-checking bench for regfile_bypass_dump: vector table, randomized
// traffic against an array model, and hand-written dump sequences.
module tb_regfile_bypass_dump;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;

   logic              clk, rst;
   logic [AW-1:0]     ra0, ra1;
   logic [NRD*AW-1:0] ra;
   logic [NRD*XLEN-1:0] rd;
   logic [XLEN-1:0]   rd0, rd1;
   logic              we0, we1;
   logic [AW-1:0]     wa0, wa1;
   logic [XLEN-1:0]   wd0, wd1;
   logic [XLEN-1:0]   display_data, dump_data;
   logic              dump_start, dump_busy, dump_valid, dump_ready, dump_done;
   logic [AW-1:0]     dump_idx;

   assign ra  = {ra1, ra0};
   assign rd0 = rd[XLEN-1:0];
   assign rd1 = rd[2*XLEN-1:XLEN];

   regfile_bypass_dump dut (
      .clk          (clk),
      .rst          (rst),
      .ra           (ra),
      .rd           (rd),
      .we0          (we0),
      .wa0          (wa0),
      .wd0          (wd0),
      .we1          (we1),
      .wa1          (wa1),
      .wd1          (wd1),
      .display_data (display_data),
      .dump_start   (dump_start),
      .dump_busy    (dump_busy),
      .dump_valid   (dump_valid),
      .dump_ready   (dump_ready),
      .dump_idx     (dump_idx),
      .dump_data    (dump_data),
      .dump_done    (dump_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [XLEN-1:0] model    [NREGS];
   logic [XLEN-1:0] exp_dump [NREGS];
   logic [AW-1:0]   qi [$];
   logic [XLEN-1:0] qd [$];
   int              done_cnt, busy_cnt;

   typedef struct {
      logic            we0;
      logic [AW-1:0]   wa0;
      logic [XLEN-1:0] wd0;
      logic            we1;
      logic [AW-1:0]   wa1;
      logic [XLEN-1:0] wd1;
      logic [AW-1:0]   ra0;
      logic [AW-1:0]   ra1;
      logic [XLEN-1:0] e0;
      logic [XLEN-1:0] e1;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference read: x0 is zero, then newest in-flight write, then stored value.
   function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (we1 && wa1 == a) return wd1;
      if (we0 && wa0 == a) return wd0;
      return model[a];
   endfunction

   task automatic commit_model();
      if (we0 && wa0 != 0) model[wa0] = wd0;
      if (we1 && wa1 != 0) model[wa1] = wd1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < NREGS; i++) model[i] = '0;
   endtask

   // Runs one complete dump from IDLE, starting and ending at the drive point.
   task automatic run_dump(input bit toggle, input int wr_at, input int exp_busy);
      bit              prev_stall = 1'b0;
      bit              fin = 1'b0;
      logic [AW-1:0]   pidx = '0;
      logic [XLEN-1:0] pdat = '0;
      qi.delete();
      qd.delete();
      done_cnt = 0;
      busy_cnt = 0;
      dump_start = 1'b1;
      cyc();
      dump_start = 1'b0;
      for (int c = 0; c < 300 && !fin; c++) begin
         we0 = 1'b0;
         we1 = 1'b0;
         dump_ready = toggle ? c[0] : 1'b1;
         if (wr_at >= 0 && dump_valid && dump_idx == AW'(wr_at)) begin
            we0 = 1'b1; wa0 = AW'(wr_at);     wd0 = 32'hAA;
            we1 = 1'b1; wa1 = AW'(wr_at + 1); wd1 = 32'hAA;
         end
         #1;
         if (c == 0) check("valid_after_start", 32'(dump_valid), 32'd1);
         if (dump_busy) busy_cnt++;
         if (dump_done) done_cnt++;
         if (prev_stall) begin
            check("hold_idx", 32'(dump_idx), 32'(pidx));
            check("hold_data", dump_data, pdat);
         end
         if (dump_valid && dump_ready) begin
            qi.push_back(dump_idx);
            qd.push_back(dump_data);
         end
         prev_stall = dump_valid && !dump_ready;
         pidx = dump_idx;
         pdat = dump_data;
         if (dump_done) fin = 1'b1;
         cyc();
      end
      we0 = 1'b0;
      we1 = 1'b0;
      check("busy_after_done", 32'(dump_busy), 32'd0);
      check("done_one_cycle", 32'(dump_done), 32'd0);
      check("word_count", 32'(qi.size()), 32'd32);
      for (int j = 0; j < qi.size() && j < NREGS; j++) begin
         check($sformatf("word_idx[%0d]", j), 32'(qi[j]), 32'(j));
         check($sformatf("word_data[%0d]", j), qd[j], exp_dump[j]);
      end
      check("done_pulses", 32'(done_cnt), 32'd1);
      check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   initial begin
      bit hit, extra_done, seen_done, seen_busy;

      rst = 1'b1;
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;
      ra0 = '0; ra1 = '0;
      dump_start = 1'b0; dump_ready = 1'b0;
      clear_model();

      // Vectors assume state after reset plus x4 = DEADBEEF.
      tbl[0]  = '{1'b1, 5'd5, 32'h11,   1'b1, 5'd5, 32'h22,   5'd5, 5'd0, 32'h22,       32'h0};
      tbl[1]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd5, 5'd4, 32'h22,       32'hDEADBEEF};
      tbl[2]  = '{1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 32'h0,    5'd7, 5'd0, 32'h1234,     32'h0};
      tbl[3]  = '{1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd7, 32'h0,        32'h1234};
      tbl[4]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd0, 5'd5, 32'h0,        32'h22};
      tbl[5]  = '{1'b1, 5'd9, 32'hAB,   1'b1, 5'd8, 32'hCD,   5'd9, 5'd8, 32'hAB,       32'hCD};
      tbl[6]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd9, 5'd8, 32'hAB,       32'hCD};
      tbl[7]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'h77,   5'd9, 5'd9, 32'h77,       32'h77};
      tbl[8]  = '{1'b1, 5'd9, 32'h55,   1'b0, 5'd0, 32'h0,    5'd9, 5'd4, 32'h55,       32'hDEADBEEF};
      tbl[9]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd9, 5'd5, 32'h55,       32'h22};
      tbl[10] = '{1'b1, 5'd3, 32'h66,   1'b1, 5'd0, 32'h99,   5'd3, 5'd0, 32'h66,       32'h0};
      tbl[11] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd3, 5'd0, 32'h66,       32'h0};

      // Power-on reset.
      repeat (2) @(posedge clk);
      #1;
      ra0 = 5'd3; ra1 = 5'd4;
      #1;
      check("rst_rd0", rd0, 32'h0);
      check("rst_rd1", rd1, 32'h0);
      check("rst_display", display_data, 32'h0);
      check("rst_busy", 32'(dump_busy), 32'd0);
      check("rst_valid", 32'(dump_valid), 32'd0);
      check("rst_done", 32'(dump_done), 32'd0);
      check("rst_idx", 32'(dump_idx), 32'd0);
      check("rst_dump_data", dump_data, 32'h0);
      rst = 1'b0;
      cyc();

      // Randomized traffic with collision-prone addresses.
      for (int n = 0; n < 400; n++) begin
         we0 = 1'($urandom_range(0, 1));
         we1 = 1'($urandom_range(0, 1));
         wa0 = AW'($urandom_range(0, 7));
         wa1 = AW'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) wa0 = AW'($urandom);
         if ($urandom_range(0, 3) == 0) wa1 = AW'($urandom);
         wd0 = $urandom;
         wd1 = $urandom;
         case ($urandom_range(0, 2))
            0:       ra0 = wa0;
            1:       ra0 = wa1;
            default: ra0 = AW'($urandom_range(0, 7));
         endcase
         case ($urandom_range(0, 2))
            0:       ra1 = wa1;
            1:       ra1 = wa0;
            default: ra1 = AW'($urandom);
         endcase
         #1;
         check("rand_rd0", rd0, exp_read(ra0));
         check("rand_rd1", rd1, exp_read(ra1));
         check("rand_display", display_data, model[4]);
         commit_model();
         cyc();
      end

      // Asynchronous reset mid-run.
      we0 = 1'b0; we1 = 1'b0;
      ra0 = 5'd4; ra1 = 5'd7;
      rst = 1'b1;
      #1;
      check("midrst_rd0", rd0, 32'h0);
      check("midrst_rd1", rd1, 32'h0);
      check("midrst_display", display_data, 32'h0);
      clear_model();
      cyc();
      rst = 1'b0;
      we0 = 1'b1; wa0 = 5'd4; wd0 = 32'hDEADBEEF;
      #1;
      check("display_not_bypassed", display_data, 32'h0);
      commit_model();
      cyc();
      we0 = 1'b0;
      #1;
      check("display_after_write", display_data, 32'hDEADBEEF);
      cyc();

      // Vector table: same-cycle bypass then commit.
      for (int i = 0; i < 12; i++) begin
         we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
         we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
         ra0 = tbl[i].ra0; ra1 = tbl[i].ra1;
         #1;
         check($sformatf("vec%0d_rd0", i), rd0, tbl[i].e0);
         check($sformatf("vec%0d_rd1", i), rd1, tbl[i].e1);
         commit_model();
         cyc();
      end
      we0 = 1'b0; we1 = 1'b0;

      // Preload xi = i*3, then dump with ready toggling.
      for (int i = 1; i < NREGS; i++) begin
         we0 = 1'b1; wa0 = AW'(i); wd0 = 32'(i * 3);
         commit_model();
         cyc();
      end
      we0 = 1'b0;
      for (int i = 0; i < NREGS; i++) exp_dump[i] = 32'(i * 3);
      run_dump(1'b1, -1, 65);

      // Writes to x10/x11 on the edge that accepts word 10.
      exp_dump[11] = 32'hAA;
      run_dump(1'b0, 10, 33);

      // Extra start while busy, then reset at idx 12.
      dump_ready = 1'b1;
      dump_start = 1'b1;
      cyc();
      dump_start = 1'b0;
      hit = 1'b0;
      extra_done = 1'b0;
      for (int c = 0; c < 60 && !hit; c++) begin
         if (dump_idx == 5'd5 && !extra_done) begin
            dump_start = 1'b1;
            cyc();
            dump_start = 1'b0;
            extra_done = 1'b1;
            check("start_ignored_idx", 32'(dump_idx), 32'd6);
            check("start_ignored_busy", 32'(dump_busy), 32'd1);
         end else if (dump_idx == 5'd12) begin
            rst = 1'b1;
            #1;
            check("rstdump_busy", 32'(dump_busy), 32'd0);
            check("rstdump_valid", 32'(dump_valid), 32'd0);
            check("rstdump_done", 32'(dump_done), 32'd0);
            check("rstdump_idx", 32'(dump_idx), 32'd0);
            hit = 1'b1;
         end else begin
            cyc();
         end
      end
      check("reached_idx12", 32'(hit), 32'd1);
      cyc();
      rst = 1'b0;
      seen_done = 1'b0;
      seen_busy = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (dump_done) seen_done = 1'b1;
         if (dump_busy) seen_busy = 1'b1;
         cyc();
      end
      check("no_done_after_rst", 32'(seen_done), 32'd0);
      check("no_restart_after_rst", 32'(seen_busy), 32'd0);

      // Fresh dump after reset: all registers cleared.
      for (int i = 0; i < NREGS; i++) exp_dump[i] = '0;
      run_dump(1'b0, -1, 33);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
